// File: rtl/frame_tx.sv
// Serial frame transmitter: preamble, MSB-first payload, optional parity, idle gap.
// Optional even-parity bit after the payload is built when FRAME_TX_PARITY_EN is defined.
module frame_tx #(
  parameter logic [3:0]  PREAMBLE   = 4'b1101,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       ser_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    PAY,
`ifdef FRAME_TX_PARITY_EN
    PAR,
`endif
    GAP
  } state_e;

  localparam logic [3:0] GapLast = 4'(GAP_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_data_q, hold_data_d;
  logic       hold_full_q, hold_full_d;
  logic       ser_q, ser_d;
  logic       accept;
  logic       load;

  assign accept = din_valid & ~hold_full_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 4'd1;
    shift_d     = shift_q;
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    load        = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (hold_full_q) begin
          state_d = PRE;
          load    = 1'b1;
        end
      end
      PRE: begin
        if (cnt_q == 4'd3) begin
          state_d = PAY;
          cnt_d   = '0;
        end
      end
      PAY: begin
        if (cnt_q == 4'd7) begin
`ifdef FRAME_TX_PARITY_EN
          state_d = PAR;
`else
          state_d = GAP;
`endif
          cnt_d   = '0;
        end
      end
`ifdef FRAME_TX_PARITY_EN
      PAR: begin
        state_d = GAP;
        cnt_d   = '0;
      end
`endif
      GAP: begin
        if (cnt_q == GapLast) begin
          cnt_d = '0;
          if (hold_full_q) begin
            state_d = PRE;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Drain and capture are exclusive: capture needs hold empty, drain needs it full.
    if (load) begin
      shift_d     = hold_data_q;
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_data_d = din;
      hold_full_d = 1'b1;
    end
  end

  // Serial bit is registered, so it is derived from the state being entered.
  always_comb begin
    ser_d = 1'b0;
    case (state_d)
      PRE:     ser_d = PREAMBLE[2'd3 - cnt_d[1:0]];
      PAY:     ser_d = shift_d[3'd7 - cnt_d[2:0]];
`ifdef FRAME_TX_PARITY_EN
      PAR:     ser_d = ^shift_d;
`endif
      default: ser_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      ser_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      ser_q       <= ser_d;
    end
  end

  assign din_ready = ~hold_full_q;
  assign ser_out   = ser_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == GAP) && (cnt_q == GapLast);

endmodule

// File: tb/tb_frame_tx.sv
// Scoreboard bench for frame_tx: queue-of-frames reference model vs. DUT outputs.
// Random bytes, back-to-back offers and mid-frame resets.
module tb_frame_tx;

  localparam logic [3:0] PRE_PAT = 4'b1101;
  localparam int         GAP     = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic       ser_out;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  frame_tx #(
    .PREAMBLE  (PRE_PAT),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .ser_out  (ser_out),
    .busy     (busy),
    .done     (done)
  );

  typedef struct packed {
    logic ser;
    logic bsy;
    logic dn;
  } obs_t;

  typedef struct packed {
    logic ser;
    logic bsy;
    logic dn;
    logic rdy;
  } exp_t;

  obs_t       line[$];
  exp_t       exp_q[$];
  bit         m_held = 1'b0;
  logic [7:0] m_byte = 8'h00;
  int         n_vec = 0;
  int         n_err = 0;

  function automatic void chk(string name, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endfunction

  // One frame as the line would carry it, cycle by cycle.
  function automatic void build_frame(logic [7:0] b);
    for (int i = 3; i >= 0; i--) line.push_back(obs_t'{PRE_PAT[i], 1'b1, 1'b0});
    for (int i = 7; i >= 0; i--) line.push_back(obs_t'{b[i], 1'b1, 1'b0});
`ifdef FRAME_TX_PARITY_EN
    line.push_back(obs_t'{^b, 1'b1, 1'b0});
`endif
    for (int g = 0; g < GAP; g++) line.push_back(obs_t'{1'b0, 1'b1, g == GAP - 1});
  endfunction

  // Reference model: a line of pending cycles plus a one-byte holding slot.
  initial begin
    exp_t e;
    bit   acc;
    forever begin
      @(posedge clk);
      if (rst) begin
        line.delete();
        m_held = 1'b0;
        e = exp_t'{1'b0, 1'b0, 1'b0, 1'b1};
      end else begin
        acc = din_valid && !m_held;
        if (line.size() > 0) void'(line.pop_front());
        if (line.size() == 0 && m_held) begin
          build_frame(m_byte);
          m_held = 1'b0;
        end
        if (acc) begin
          m_held = 1'b1;
          m_byte = din;
        end
        if (line.size() == 0) e = exp_t'{1'b0, 1'b0, 1'b0, !m_held};
        else e = exp_t'{line[0].ser, line[0].bsy, line[0].dn, !m_held};
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: one scoreboard entry per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_empty: got no entry expected one at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (rst) begin
          chk("rst_ser", ser_out, 1'b0);
          chk("rst_busy", busy, 1'b0);
          chk("rst_done", done, 1'b0);
          chk("rst_ready", din_ready, 1'b1);
        end else begin
          chk("ser_out", ser_out, e.ser);
          chk("busy", busy, e.bsy);
          chk("done", done, e.dn);
          chk("din_ready", din_ready, e.rdy);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    logic r;
    din       = b;
    din_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      r = din_ready;
      @(posedge clk);
      #2;
      if (r) begin
        din_valid = 1'b0;
        return;
      end
    end
    din_valid = 1'b0;
    n_vec++;
    n_err++;
    $display("FAIL send_timeout: got no accept expected accept of %h", b);
  endtask

  task automatic pulse_rst();
    din_valid = 1'b0;
    rst       = 1'b1;
    #1;
    chk("async_ser", ser_out, 1'b0);
    chk("async_busy", busy, 1'b0);
    chk("async_done", done, 1'b0);
    chk("async_ready", din_ready, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    idle(2);
    send(8'hA5);
    idle(20);
    send(8'h3C);
    send(8'hFF);
    send(8'h5A);
    idle(50);
    send(8'h81);
    repeat (8) @(posedge clk);
    #2;
    pulse_rst();
    send(8'h01);
    idle(25);
    send(8'h00);
    send(8'h07);
    send(8'h03);
    idle(30);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        idle($urandom_range(0, 12));
        pulse_rst();
      end else begin
        if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 14));
        send(8'($urandom));
      end
    end
    idle(40);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
